// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit positions and the
// operand forwarding select encoding.
package pipe_pkg;

    localparam int CTL_WREG  = 0;
    localparam int CTL_M2REG = 1;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Resolves one source operand from the register file or the EX/MEM/WB
// bypass paths; the nearest producer wins and register 0 is always zero.
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RW    = 5
) (
    input  logic [RW-1:0]    rn,
    input  logic [WIDTH-1:0] rfd,
    input  logic             exv,
    input  logic [RW-1:0]    exrn,
    input  logic [WIDTH-1:0] exd,
    input  logic             memv,
    input  logic [RW-1:0]    memrn,
    input  logic [WIDTH-1:0] memd,
    input  logic             wbv,
    input  logic [RW-1:0]    wbrn,
    input  logic [WIDTH-1:0] wbd,
    output logic [WIDTH-1:0] q
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_RF;
        if (rn != '0) begin
            if (exv && (exrn == rn))
                sel = FWD_EX;
            else if (memv && (memrn == rn))
                sel = FWD_MEM;
            else if (wbv && (wbrn == rn))
                sel = FWD_WB;
        end
    end

    always_comb begin
        q = '0;
        if (rn != '0) begin
            case (sel)
                FWD_EX:  q = exd;
                FWD_MEM: q = memd;
                FWD_WB:  q = wbd;
                default: q = rfd;
            endcase
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-stage operand resolver with load-use stall detection and the
// ID/EX pipeline register.
module id_operand_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RW    = 5,
    parameter int CTLW  = 9
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [RW-1:0]    rs,
    input  logic [RW-1:0]    rt,
    input  logic             usea,
    input  logic             useb,
    input  logic [WIDTH-1:0] qa,
    input  logic [WIDTH-1:0] qb,
    input  logic [WIDTH-1:0] dimm,
    input  logic [RW-1:0]    drn,
    input  logic [CTLW-1:0]  dctl,
    input  logic             flush,
    input  logic [RW-1:0]    ern,
    input  logic [WIDTH-1:0] ealu,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [RW-1:0]    mrn,
    input  logic [WIDTH-1:0] malu,
    input  logic [WIDTH-1:0] mmo,
    input  logic             wwreg,
    input  logic [RW-1:0]    wrn,
    input  logic [WIDTH-1:0] wd,
    output logic             wpcir,
    output logic [WIDTH-1:0] ea,
    output logic [WIDTH-1:0] eb,
    output logic [WIDTH-1:0] eimm,
    output logic [RW-1:0]    ern_o,
    output logic [CTLW-1:0]  ectl,
    output logic [31:0]      stall_cnt
);

    logic             ex_alu_wr;
    logic             ex_load;
    logic             hazard;
    logic             bubble;
    logic [WIDTH-1:0] mem_data;
    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;

    // A load in EX has no data yet, so it can only be bypassed from MEM onward.
    assign ex_alu_wr = ectl[CTL_WREG] & ~ectl[CTL_M2REG];
    assign ex_load   = ectl[CTL_WREG] &  ectl[CTL_M2REG];
    assign mem_data  = mm2reg ? mmo : malu;

    assign hazard = ex_load && (ern != '0) &&
                    ((usea && (ern == rs)) || (useb && (ern == rt)));
    assign bubble = hazard | flush;
    assign wpcir  = ~hazard | flush;

    fwd_mux #(.WIDTH(WIDTH), .RW(RW)) u_fwd_a (
        .rn    (rs),
        .rfd   (qa),
        .exv   (ex_alu_wr),
        .exrn  (ern),
        .exd   (ealu),
        .memv  (mwreg),
        .memrn (mrn),
        .memd  (mem_data),
        .wbv   (wwreg),
        .wbrn  (wrn),
        .wbd   (wd),
        .q     (fwd_a)
    );

    fwd_mux #(.WIDTH(WIDTH), .RW(RW)) u_fwd_b (
        .rn    (rt),
        .rfd   (qb),
        .exv   (ex_alu_wr),
        .exrn  (ern),
        .exd   (ealu),
        .memv  (mwreg),
        .memrn (mrn),
        .memd  (mem_data),
        .wbv   (wwreg),
        .wbrn  (wrn),
        .wbd   (wd),
        .q     (fwd_b)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ea    <= '0;
            eb    <= '0;
            eimm  <= '0;
            ern_o <= '0;
            ectl  <= '0;
        end else if (bubble) begin
            ea    <= '0;
            eb    <= '0;
            eimm  <= '0;
            ern_o <= '0;
            ectl  <= '0;
        end else begin
            ea    <= fwd_a;
            eb    <= fwd_b;
            eimm  <= dimm;
            ern_o <= drn;
            ectl  <= dctl;
        end
    end

    // Only genuine stalls are counted; a flushed hazard costs no cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            stall_cnt <= '0;
        else if (hazard && !flush && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed table-driven bench for id_operand_stage; EX feedback (ern) is
// wired back from the block's own ern_o as in the real pipeline.
module tb_id_operand_stage;

    typedef struct {
        logic [4:0]  rs, rt;
        logic        usea, useb;
        logic [31:0] qa, qb, dimm;
        logic [4:0]  drn;
        logic [8:0]  dctl;
        logic        flush;
        logic [31:0] ealu;
        logic        mwreg, mm2reg;
        logic [4:0]  mrn;
        logic [31:0] malu, mmo;
        logic        wwreg;
        logic [4:0]  wrn;
        logic [31:0] wd;
        logic        xwpcir;
        logic [31:0] xea, xeb, ximm;
        logic [4:0]  xrn;
        logic [8:0]  xctl;
        logic [31:0] xstall;
    } vec_t;

    logic        clk = 1'b0;
    logic        clrn;
    logic [4:0]  rs, rt, drn, mrn, wrn;
    logic        usea, useb, flush, mwreg, mm2reg, wwreg;
    logic [31:0] qa, qb, dimm, ealu, malu, mmo, wd;
    logic [8:0]  dctl;
    logic        wpcir;
    logic [31:0] ea, eb, eimm, stall_cnt;
    logic [4:0]  ern_o;
    logic [8:0]  ectl;

    int checks = 0;
    int fails  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    id_operand_stage dut (
        .clk(clk), .clrn(clrn), .rs(rs), .rt(rt), .usea(usea), .useb(useb),
        .qa(qa), .qb(qb), .dimm(dimm), .drn(drn), .dctl(dctl), .flush(flush),
        .ern(ern_o), .ealu(ealu), .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
        .malu(malu), .mmo(mmo), .wwreg(wwreg), .wrn(wrn), .wd(wd),
        .wpcir(wpcir), .ea(ea), .eb(eb), .eimm(eimm), .ern_o(ern_o),
        .ectl(ectl), .stall_cnt(stall_cnt)
    );

    function automatic vec_t blankVec();
        vec_t v;
        v.rs = 0; v.rt = 0; v.usea = 0; v.useb = 0; v.qa = 0; v.qb = 0;
        v.dimm = 0; v.drn = 0; v.dctl = 0; v.flush = 0; v.ealu = 0;
        v.mwreg = 0; v.mm2reg = 0; v.mrn = 0; v.malu = 0; v.mmo = 0;
        v.wwreg = 0; v.wrn = 0; v.wd = 0; v.xwpcir = 1; v.xea = 0;
        v.xeb = 0; v.ximm = 0; v.xrn = 0; v.xctl = 0; v.xstall = 0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rs = v.rs; rt = v.rt; usea = v.usea; useb = v.useb; qa = v.qa; qb = v.qb;
        dimm = v.dimm; drn = v.drn; dctl = v.dctl; flush = v.flush; ealu = v.ealu;
        mwreg = v.mwreg; mm2reg = v.mm2reg; mrn = v.mrn; malu = v.malu; mmo = v.mmo;
        wwreg = v.wwreg; wrn = v.wrn; wd = v.wd;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        drive(v);
        #1;
        checkOutput($sformatf("v%0d wpcir", idx), {31'd0, wpcir}, {31'd0, v.xwpcir});
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d ea", idx), ea, v.xea);
        checkOutput($sformatf("v%0d eb", idx), eb, v.xeb);
        checkOutput($sformatf("v%0d eimm", idx), eimm, v.ximm);
        checkOutput($sformatf("v%0d ern_o", idx), {27'd0, ern_o}, {27'd0, v.xrn});
        checkOutput($sformatf("v%0d ectl", idx), {23'd0, ectl}, {23'd0, v.xctl});
        checkOutput($sformatf("v%0d stall_cnt", idx), stall_cnt, v.xstall);
    endtask

    initial begin
        vec_t v;

        // v0: plain register-file read, EX holds a reset bubble
        v = blankVec(); v.rs = 1; v.rt = 2; v.usea = 1; v.useb = 1; v.qa = 32'h11; v.qb = 32'h22;
        v.dimm = 32'h100; v.drn = 3; v.dctl = 9'h0F1;
        v.xea = 32'h11; v.xeb = 32'h22; v.ximm = 32'h100; v.xrn = 3; v.xctl = 9'h0F1;
        vecs.push_back(v);
        // v1: EX (r3, ealu=5) beats MEM (r3, malu=9); loads lw r4 into EX
        v = blankVec(); v.rs = 3; v.rt = 5; v.usea = 1; v.useb = 1; v.qa = 32'hEE; v.qb = 32'h55;
        v.ealu = 32'h5; v.mwreg = 1; v.mrn = 3; v.malu = 32'h9; v.dimm = 32'h200; v.drn = 4; v.dctl = 9'h003;
        v.xea = 32'h5; v.xeb = 32'h55; v.ximm = 32'h200; v.xrn = 4; v.xctl = 9'h003;
        vecs.push_back(v);
        // v2: load-use on rt=4 -> stall and bubble
        v = blankVec(); v.rs = 1; v.rt = 4; v.usea = 1; v.useb = 1; v.qa = 32'h77; v.qb = 32'hBAD;
        v.dimm = 32'h300; v.drn = 6; v.dctl = 9'h001;
        v.xwpcir = 0; v.xstall = 1;
        vecs.push_back(v);
        // v3: same instruction retried, load now in MEM -> eb = mmo
        v = blankVec(); v.rs = 1; v.rt = 4; v.usea = 1; v.useb = 1; v.qa = 32'h77; v.qb = 32'hBAD;
        v.mwreg = 1; v.mm2reg = 1; v.mrn = 4; v.mmo = 32'hDEAD; v.malu = 32'h1234;
        v.dimm = 32'h300; v.drn = 6; v.dctl = 9'h001;
        v.xea = 32'h77; v.xeb = 32'hDEAD; v.ximm = 32'h300; v.xrn = 6; v.xctl = 9'h001; v.xstall = 1;
        vecs.push_back(v);
        // v4: MEM beats WB on rs=2, EX (r6) feeds rt; loads lw r8
        v = blankVec(); v.rs = 2; v.rt = 6; v.usea = 1; v.useb = 1; v.qa = 32'h1; v.qb = 32'h2;
        v.ealu = 32'h66; v.mwreg = 1; v.mrn = 2; v.malu = 32'h99; v.wwreg = 1; v.wrn = 2; v.wd = 32'h88;
        v.dimm = 32'h400; v.drn = 8; v.dctl = 9'h003;
        v.xea = 32'h99; v.xeb = 32'h66; v.ximm = 32'h400; v.xrn = 8; v.xctl = 9'h003; v.xstall = 1;
        vecs.push_back(v);
        // v5: load-use on r8 but flushed -> no stall, bubble, count unchanged
        v = blankVec(); v.rs = 8; v.usea = 1; v.flush = 1; v.qa = 32'h5A;
        v.dimm = 32'h500; v.drn = 9; v.dctl = 9'h001; v.xstall = 1;
        vecs.push_back(v);
        // v6: WB bypass on r7, writer to r0 ignored; loads lw r0
        v = blankVec(); v.rs = 7; v.rt = 0; v.usea = 1; v.useb = 1; v.qa = 32'h1; v.qb = 32'h33;
        v.wwreg = 1; v.wrn = 7; v.wd = 32'hAB; v.mwreg = 1; v.mrn = 0; v.malu = 32'h5;
        v.dimm = 32'h600; v.drn = 0; v.dctl = 9'h003;
        v.xea = 32'hAB; v.xeb = 32'h0; v.ximm = 32'h600; v.xrn = 0; v.xctl = 9'h003; v.xstall = 1;
        vecs.push_back(v);
        // v7: lw r0 in EX with rs=0 is not a hazard; r0 reads zero despite WB to r0
        v = blankVec(); v.rs = 0; v.rt = 9; v.usea = 1; v.useb = 0; v.qa = 32'h44; v.qb = 32'h99;
        v.wwreg = 1; v.wrn = 0; v.wd = 32'h55; v.dimm = 32'h700; v.drn = 9; v.dctl = 9'h1FD;
        v.xea = 32'h0; v.xeb = 32'h99; v.ximm = 32'h700; v.xrn = 9; v.xctl = 9'h1FD; v.xstall = 1;
        vecs.push_back(v);
        // v8: EX (r9, non-load) feeds both operands over MEM; loads lw r10
        v = blankVec(); v.rs = 9; v.rt = 9; v.usea = 1; v.useb = 1; v.qa = 32'h3; v.qb = 32'h4;
        v.ealu = 32'h1EE; v.mwreg = 1; v.mrn = 9; v.malu = 32'h2; v.dimm = 32'h800; v.drn = 10; v.dctl = 9'h003;
        v.xea = 32'h1EE; v.xeb = 32'h1EE; v.ximm = 32'h800; v.xrn = 10; v.xctl = 9'h003; v.xstall = 1;
        vecs.push_back(v);
        // v9: lw r10 in EX, ID names r10 but reads neither operand -> no stall, no EX bypass
        v = blankVec(); v.rs = 10; v.rt = 10; v.usea = 0; v.useb = 0; v.qa = 32'h10; v.qb = 32'h20;
        v.ealu = 32'hF00; v.dimm = 32'h900;
        v.xea = 32'h10; v.xeb = 32'h20; v.ximm = 32'h900; v.xstall = 1;
        vecs.push_back(v);

        clrn = 1'b0;
        drive(blankVec());
        #12;
        checkOutput("reset ea", ea, 32'h0);
        checkOutput("reset ectl", {23'd0, ectl}, 32'h0);
        checkOutput("reset stall_cnt", stall_cnt, 32'h0);
        checkOutput("reset wpcir", {31'd0, wpcir}, 32'h1);
        @(negedge clk);
        clrn = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], i);

        // Mid-stall async reset: set up lw r4 in EX, create the hazard, reset between edges
        v = blankVec(); v.rs = 1; v.qa = 32'h1; v.dimm = 32'hA; v.drn = 4; v.dctl = 9'h003;
        v.xea = 32'h1; v.ximm = 32'hA; v.xrn = 4; v.xctl = 9'h003; v.xstall = 1;
        applyStimulus(v, 10);
        @(negedge clk);
        v = blankVec(); v.rt = 4; v.useb = 1; v.qb = 32'h7;
        drive(v);
        #1;
        checkOutput("midstall wpcir", {31'd0, wpcir}, 32'h0);
        #1;
        clrn = 1'b0;
        #1;
        checkOutput("async ea", ea, 32'h0);
        checkOutput("async eimm", eimm, 32'h0);
        checkOutput("async ern_o", {27'd0, ern_o}, 32'h0);
        checkOutput("async ectl", {23'd0, ectl}, 32'h0);
        checkOutput("async stall_cnt", stall_cnt, 32'h0);
        checkOutput("async wpcir", {31'd0, wpcir}, 32'h1);
        @(negedge clk);
        clrn = 1'b1;
        v.xeb = 32'h7; v.xstall = 0;
        applyStimulus(v, 11);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
